// File: rtl/vregfile_seq.sv
// Sequenced vector register file: fetches up to three source registers per group, streams ELEN elements out and results back, writes the result register.
// Latency: RAM read data one cycle after request; per group 1..3 read cycles + stream + 1 write cycle (+1 refetch cycle after a write-back).
// Backpressure: op_valid_o/op_ready_i and res_valid_i/res_ready_o handshakes stall STREAM; start_i is ignored while busy_o is high.
// Optional feature macro: VREGFILE_ERR_EN (reject misaligned or oversized register groups with an err_o pulse).
module vregfile_seq #(
  parameter int VLEN      = 128,
  parameter int ELEN      = 32,
  parameter int AddrWidth = 5,
  parameter int MaxLmul   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           num_operands_i,
  input  logic                 we_i,
  input  logic [1:0]           lmul_i,
  input  logic [AddrWidth-1:0] raddr_a_i,
  input  logic [AddrWidth-1:0] raddr_b_i,
  input  logic [AddrWidth-1:0] raddr_c_i,
  input  logic [AddrWidth-1:0] waddr_i,
  output logic                 busy_o,
  output logic                 op_valid_o,
  input  logic                 op_ready_i,
  output logic [ELEN-1:0]      rdata_a_o,
  output logic [ELEN-1:0]      rdata_b_o,
  output logic [ELEN-1:0]      rdata_c_o,
  input  logic                 res_valid_i,
  output logic                 res_ready_o,
  input  logic [ELEN-1:0]      wdata_i,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int COUNT = VLEN / ELEN;
  localparam int CntW  = $clog2(COUNT + 1);
  localparam logic [CntW-1:0] CountC  = CntW'(COUNT);
  localparam logic [1:0]      LmulMax = 2'($clog2(MaxLmul));

  typedef enum logic [2:0] {IDLE, READ1, READ2, READ3, STREAM, WRITE} state_e;
  state_e state_q, state_d;

  logic [VLEN-1:0]      mem_q [2**AddrWidth];
  logic [VLEN-1:0]      rdata_q;
  logic                 rvalid_q;
  logic                 mem_req, mem_we;
  logic [AddrWidth-1:0] mem_addr;

  logic [1:0]           nops_q, lmul_q;
  logic                 wen_q;
  logic [AddrWidth-1:0] ra_q, rb_q, rc_q, rw_q;
  logic [2:0]           g_q, g_last;
  logic [CntW-1:0]      issue_q, res_q;
  logic [VLEN-1:0]      rs1_q, rs2_q, rs3_q, rd_q;

  logic                 start_ok;
  logic [1:0]           lmul_eff;
  logic                 last_grp, op_fire, res_fire;
  logic [AddrWidth-1:0] g_ext, g_nxt_ext;

  assign g_ext     = AddrWidth'(g_q);
  assign g_nxt_ext = AddrWidth'(g_q + 3'd1);
  assign g_last    = 3'((1 << lmul_q) - 1);
  assign last_grp  = (g_q == g_last);
  assign op_fire   = op_valid_o && op_ready_i;
  assign res_fire  = res_valid_i && res_ready_o;

`ifdef VREGFILE_ERR_EN
  logic                 err_q;
  logic [AddrWidth-1:0] mask;

  // Request legality: group size in range and every used base aligned to the group size.
  always_comb begin
    lmul_eff = lmul_i;
    mask     = AddrWidth'((1 << lmul_i) - 1);
    start_ok = !((lmul_i > LmulMax)
              || ((num_operands_i >= 2'd1) && |(raddr_a_i & mask))
              || ((num_operands_i >= 2'd2) && |(raddr_b_i & mask))
              || ((num_operands_i == 2'd3) && |(raddr_c_i & mask))
              || (we_i && |(waddr_i & mask)));
  end

  // Rejection pulse lands in the cycle after the offending start.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= start_i && (state_q == IDLE) && !start_ok;
  end
  assign err_o = err_q;
`else
  // Oversized group requests are clamped to the largest supported group.
  always_comb begin
    lmul_eff = (lmul_i > LmulMax) ? LmulMax : lmul_i;
    start_ok = 1'b1;
  end
  assign err_o = 1'b0;
`endif

  // Next state, RAM port control and handshake outputs; reset blanks everything, including RAM writes.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = ra_q + g_ext;
    busy_o      = 1'b0;
    op_valid_o  = 1'b0;
    res_ready_o = 1'b0;
    done_o      = 1'b0;
    if (!rst_i) begin
      busy_o = (state_q != IDLE);
      case (state_q)
        IDLE: if (start_i && start_ok) begin
          if (num_operands_i == 2'd0) state_d = STREAM;
          else begin
            state_d  = READ1;
            mem_req  = 1'b1;
            mem_addr = raddr_a_i;
          end
        end
        // After a write-back the port was busy, so the a-operand fetch is issued here first.
        READ1: if (!rvalid_q) begin
          mem_req  = 1'b1;
          mem_addr = ra_q + g_ext;
        end else if (nops_q >= 2'd2) begin
          state_d  = READ2;
          mem_req  = 1'b1;
          mem_addr = rb_q + g_ext;
        end else state_d = STREAM;
        READ2: if (nops_q == 2'd3) begin
          state_d  = READ3;
          mem_req  = 1'b1;
          mem_addr = rc_q + g_ext;
        end else state_d = STREAM;
        READ3: state_d = STREAM;
        STREAM: begin
          op_valid_o  = (issue_q < CountC);
          res_ready_o = wen_q && (res_q < CountC);
          if ((issue_q == CountC) && (!wen_q || (res_q == CountC))) state_d = WRITE;
        end
        WRITE: begin
          mem_we   = wen_q;
          mem_addr = rw_q + g_ext;
          if (last_grp) begin
            done_o  = 1'b1;
            state_d = IDLE;
          end else if (nops_q == 2'd0) state_d = STREAM;
          else begin
            state_d = READ1;
            if (!wen_q) begin
              mem_req  = 1'b1;
              mem_addr = ra_q + g_nxt_ext;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Single-port RAM: one write or one registered read per cycle; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_addr] <= rd_q;
    if (mem_req) rdata_q <= mem_q[mem_addr];
  end

  // State, configuration latch, operand capture/shift, result assembly and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      nops_q   <= '0;
      lmul_q   <= '0;
      wen_q    <= 1'b0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      rw_q     <= '0;
      g_q      <= '0;
      issue_q  <= '0;
      res_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs3_q    <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= mem_req && !mem_we;
      if ((state_q == IDLE) && start_i && start_ok) begin
        nops_q <= num_operands_i;
        lmul_q <= lmul_eff;
        wen_q  <= we_i;
        ra_q   <= raddr_a_i;
        rb_q   <= raddr_b_i;
        rc_q   <= raddr_c_i;
        rw_q   <= waddr_i;
        g_q    <= '0;
      end
      if ((state_q == READ1) && rvalid_q) rs1_q <= rdata_q;
      if (state_q == READ2) rs2_q <= rdata_q;
      if (state_q == READ3) rs3_q <= rdata_q;
      if (state_q == STREAM) begin
        if (op_fire) begin
          rs1_q   <= rs1_q << ELEN;
          rs2_q   <= rs2_q << ELEN;
          rs3_q   <= rs3_q << ELEN;
          issue_q <= issue_q + CntW'(1);
        end
        if (res_fire) begin
          rd_q  <= (rd_q << ELEN) | VLEN'(wdata_i);
          res_q <= res_q + CntW'(1);
        end
      end else begin
        issue_q <= '0;
        res_q   <= '0;
      end
      if ((state_q == WRITE) && !last_grp) g_q <= g_q + 3'd1;
    end
  end

  assign rdata_a_o = (nops_q >= 2'd1) ? rs1_q[VLEN-1 -: ELEN] : '0;
  assign rdata_b_o = (nops_q >= 2'd2) ? rs2_q[VLEN-1 -: ELEN] : '0;
  assign rdata_c_o = (nops_q == 2'd3) ? rs3_q[VLEN-1 -: ELEN] : '0;

endmodule

// File: tb/tb_vregfile_seq.sv
// Directed bench for vregfile_seq: preloads registers through result-only ops,
// runs source/result ops with varied handshakes and reads registers back through the source stream.
module tb_vregfile_seq;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, we_i, op_ready_i, res_valid_i;
  logic [1:0]  num_operands_i, lmul_i;
  logic [4:0]  raddr_a_i, raddr_b_i, raddr_c_i, waddr_i;
  logic        busy_o, op_valid_o, res_ready_o, done_o, err_o;
  logic [31:0] rdata_a_o, rdata_b_o, rdata_c_o, wdata_i;

  int tests = 0;
  int fails = 0;
  int done_cnt;
  logic [31:0] issued_a[$], issued_b[$], issued_c[$];
  logic [31:0] pre_q[$], exp_q[$], pend_v[$];
  int          pend_t[$];

  vregfile_seq #(.VLEN(128), .ELEN(32), .AddrWidth(5), .MaxLmul(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .num_operands_i(num_operands_i),
    .we_i(we_i), .lmul_i(lmul_i), .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
    .raddr_c_i(raddr_c_i), .waddr_i(waddr_i), .busy_o(busy_o), .op_valid_o(op_valid_o),
    .op_ready_i(op_ready_i), .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o),
    .rdata_c_o(rdata_c_o), .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .wdata_i(wdata_i), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare a captured stream against exp_q element by element.
  task automatic chk_stream(input string tag, input int which);
    int n;
    logic [31:0] v;
    n = (which == 0) ? issued_a.size() : issued_b.size();
    chk({tag, "_len"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      v = 32'hBAD0_0000;
      if (i < n) v = (which == 0) ? issued_a[i] : issued_b[i];
      chk($sformatf("%s[%0d]", tag, i), v, exp_q[i]);
    end
  endtask

  // Run one operation from the current negedge until busy_o drops (bounded).
  // sum=1: each issued element set produces a result a+b+c+add, delivered 'delay' cycles later.
  // sum=0: results come from pre_q, available immediately.
  task automatic do_op(input logic [1:0] nops, input logic we, input logic [1:0] lmul,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic [4:0] w, input bit toggle, input int delay,
                       input bit sum, input logic [31:0] add);
    int cyc;
    issued_a.delete(); issued_b.delete(); issued_c.delete();
    pend_v.delete(); pend_t.delete();
    done_cnt = 0;
    if (!sum) begin
      foreach (pre_q[i]) begin
        pend_v.push_back(pre_q[i]);
        pend_t.push_back(0);
      end
      pre_q.delete();
    end
    start_i = 1'b1; num_operands_i = nops; we_i = we; lmul_i = lmul;
    raddr_a_i = a; raddr_b_i = b; raddr_c_i = c; waddr_i = w;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 0;
    while (busy_o && cyc < 2000) begin
      if (done_o) done_cnt++;
      op_ready_i = toggle ? (cyc % 2 == 1) : 1'b1;
      if (op_valid_o && op_ready_i) begin
        issued_a.push_back(rdata_a_o);
        issued_b.push_back(rdata_b_o);
        issued_c.push_back(rdata_c_o);
        if (sum) begin
          pend_v.push_back(rdata_a_o + rdata_b_o + rdata_c_o + add);
          pend_t.push_back(cyc + delay);
        end
      end
      res_valid_i = (pend_v.size() > 0) && (pend_t[0] <= cyc);
      wdata_i     = res_valid_i ? pend_v[0] : 32'h0;
      if (res_valid_i && res_ready_o) begin
        void'(pend_v.pop_front());
        void'(pend_t.pop_front());
      end
      @(negedge clk_i);
      cyc++;
    end
    op_ready_i = 1'b0; res_valid_i = 1'b0; wdata_i = 32'h0;
    chk("op_terminates", {31'b0, busy_o}, 32'h0);
  endtask

  task automatic preload(input logic [4:0] w, input logic [1:0] lmul);
    do_op(2'd0, 1'b1, lmul, 5'd0, 5'd0, 5'd0, w, 1'b0, 0, 1'b0, 32'h0);
  endtask

  task automatic readback(input logic [4:0] a, input logic [1:0] lmul);
    do_op(2'd1, 1'b0, lmul, a, 5'd0, 5'd0, 5'd0, 1'b0, 0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; we_i = 1'b0; op_ready_i = 1'b0; res_valid_i = 1'b0;
    num_operands_i = 2'd0; lmul_i = 2'd0; wdata_i = 32'h0;
    raddr_a_i = 5'd0; raddr_b_i = 5'd0; raddr_c_i = 5'd0; waddr_i = 5'd0;
    repeat (2) @(negedge clk_i);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_op_valid", {31'b0, op_valid_o}, 32'h0);
    chk("rst_res_ready", {31'b0, res_ready_o}, 32'h0);
    chk("rst_done", {31'b0, done_o}, 32'h0);
    chk("rst_err", {31'b0, err_o}, 32'h0);
    chk("rst_rdata_a", rdata_a_o, 32'h0);
    chk("rst_rdata_b", rdata_b_o, 32'h0);
    chk("rst_rdata_c", rdata_c_o, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // v1 = 4,3,2,1 ; v2 = 0x40,0x30,0x20,0x10 (most significant element first)
    pre_q = '{32'h4, 32'h3, 32'h2, 32'h1};
    preload(5'd1, 2'd0);
    chk("preload_done", 32'(done_cnt), 32'd1);
    pre_q = '{32'h40, 32'h30, 32'h20, 32'h10};
    preload(5'd2, 2'd0);

    // v3 = v1 + v2 with free-flowing handshakes
    do_op(2'd2, 1'b1, 2'd0, 5'd1, 5'd2, 5'd0, 5'd3, 1'b0, 0, 1'b1, 32'h0);
    exp_q = '{32'h4, 32'h3, 32'h2, 32'h1};
    chk_stream("add_a", 0);
    exp_q = '{32'h40, 32'h30, 32'h20, 32'h10};
    chk_stream("add_b", 1);
    for (int i = 0; i < issued_c.size(); i++) chk($sformatf("unused_c[%0d]", i), issued_c[i], 32'h0);
    chk("add_done", 32'(done_cnt), 32'd1);
    readback(5'd3, 2'd0);
    exp_q = '{32'h44, 32'h33, 32'h22, 32'h11};
    chk_stream("v3", 0);

    // Same add into v5 with op_ready toggling and results delayed three cycles
    do_op(2'd2, 1'b1, 2'd0, 5'd1, 5'd2, 5'd0, 5'd5, 1'b1, 3, 1'b1, 32'h0);
    exp_q = '{32'h4, 32'h3, 32'h2, 32'h1};
    chk_stream("bp_a", 0);
    chk("bp_done", 32'(done_cnt), 32'd1);
    readback(5'd5, 2'd0);
    exp_q = '{32'h44, 32'h33, 32'h22, 32'h11};
    chk_stream("v5", 0);

    // Group of four: v4..v7 = 0x400..0x40F, then v8..v11 = v4..v7 + 0x100
    for (int k = 0; k < 16; k++) pre_q.push_back(32'h400 + 32'(k));
    preload(5'd4, 2'd2);
    chk("grp_preload_done", 32'(done_cnt), 32'd1);
    do_op(2'd1, 1'b1, 2'd2, 5'd4, 5'd0, 5'd0, 5'd8, 1'b0, 0, 1'b1, 32'h100);
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(32'h400 + 32'(k));
    chk_stream("grp_src", 0);
    chk("grp_done", 32'(done_cnt), 32'd1);
    readback(5'd8, 2'd2);
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(32'h500 + 32'(k));
    chk_stream("grp_dst", 0);

    // Reset during STREAM of a write-back op into v3: no write, no done
    start_i = 1'b1; num_operands_i = 2'd1; we_i = 1'b1; lmul_i = 2'd0;
    raddr_a_i = 5'd1; waddr_i = 5'd3;
    @(negedge clk_i);
    start_i = 1'b0; op_ready_i = 1'b1; res_valid_i = 1'b1; wdata_i = 32'hDEAD;
    done_cnt = 0;
    @(negedge clk_i);
    chk("abort_in_stream", {31'b0, op_valid_o}, 32'h1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("abort_busy", {31'b0, busy_o}, 32'h0);
    chk("abort_op_valid", {31'b0, op_valid_o}, 32'h0);
    chk("abort_res_ready", {31'b0, res_ready_o}, 32'h0);
    rst_i = 1'b0; op_ready_i = 1'b0; res_valid_i = 1'b0; wdata_i = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (done_o || busy_o) done_cnt++;
      @(negedge clk_i);
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    readback(5'd3, 2'd0);
    exp_q = '{32'h44, 32'h33, 32'h22, 32'h11};
    chk_stream("abort_v3", 0);

    // Misaligned pair v3,v4 runs normally in the default build
    do_op(2'd1, 1'b0, 2'd1, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 0, 1'b0, 32'h0);
    exp_q = '{32'h44, 32'h33, 32'h22, 32'h11, 32'h400, 32'h401, 32'h402, 32'h403};
    chk_stream("pair_v3v4", 0);
    chk("pair_err", {31'b0, err_o}, 32'h0);
    chk("pair_done", 32'(done_cnt), 32'd1);

    // Address wrap: group at v31 continues at v0
    pre_q = '{32'h3100, 32'h3101, 32'h3102, 32'h3103};
    preload(5'd31, 2'd0);
    pre_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    preload(5'd0, 2'd0);
    readback(5'd31, 2'd1);
    exp_q = '{32'h3100, 32'h3101, 32'h3102, 32'h3103, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
    chk_stream("wrap", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vregfile_seq.md
VREGFILE_SEQ -- requirements
Module: vregfile_seq

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector register width in bits.
REQ-002 SHALL have parameter ELEN, default 32, element width in bits; VLEN SHALL be a multiple of ELEN.
REQ-003 SHALL have parameter AddrWidth, default 5, register address width; depth is 2**AddrWidth.
REQ-004 SHALL have parameter MaxLmul, default 8, largest register group size (1, 2, 4 or 8).
REQ-005 SHALL define COUNT = VLEN/ELEN.
REQ-006 clk_i  in  1  single clock, all logic on rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 start_i  in  1  operation request, sampled only in IDLE.
REQ-009 num_operands_i  in  2  source count 0..3, sampled with start_i.
REQ-010 we_i  in  1  result write-back enable, sampled with start_i.
REQ-011 lmul_i  in  2  log2 of group size, sampled with start_i.
REQ-012 raddr_a_i, raddr_b_i, raddr_c_i, waddr_i  in  AddrWidth each  base register addresses, sampled with start_i.
REQ-013 busy_o  out  1  high in every state except IDLE.
REQ-014 op_valid_o  out  1; op_ready_i  in  1  source element stream handshake.
REQ-015 rdata_a_o, rdata_b_o, rdata_c_o  out  ELEN each  current source elements, most significant element first.
REQ-016 res_valid_i  in  1; res_ready_o  out  1; wdata_i  in  ELEN  result element stream.
REQ-017 done_o  out  1  one-cycle pulse at operation completion.
REQ-018 err_o  out  1  one-cycle pulse on rejected request.

Function
REQ-019 SHALL contain one single-port VLEN-wide RAM with read data valid one cycle after request.
REQ-020 SHALL implement states IDLE, READ1, READ2, READ3, STREAM and WRITE.
REQ-021 IDLE: start_i=1 SHALL latch all config, clear group index g, and go to READ1 issuing a read of raddr_a+g, or go to STREAM if num_operands=0.
REQ-022 READ1 and READ2 SHALL capture RAM data into rs1 and rs2 respectively, then issue the next read (b+g, c+g) if more operands remain, else go to STREAM.
REQ-023 READ3 SHALL capture rs3 and go to STREAM.
REQ-024 STREAM: op_valid_o SHALL be high while fewer than COUNT elements have been issued; each op_valid_o&&op_ready_i SHALL shift the used source registers left by ELEN.
REQ-025 STREAM: res_ready_o SHALL be high iff we=1 and fewer than COUNT results have been received; each transfer SHALL shift wdata_i into rd from the LSB.
REQ-026 Issue and result counts SHALL be independent; results MAY precede issue completion.
REQ-027 STREAM SHALL exit to WRITE in the cycle after COUNT issued and, if we=1, COUNT received.
REQ-028 WRITE SHALL write rd to waddr+g if we=1; if g < 2**lmul-1 it SHALL increment g and re-enter READ1 (or STREAM if num_operands=0), else pulse done_o and go to IDLE.
REQ-029 Address arithmetic base+g SHALL wrap modulo 2**AddrWidth.
REQ-030 Unused source outputs SHALL read zero; start_i while busy SHALL be ignored.
REQ-031 lmul_i values above log2(MaxLmul) SHALL be clamped to log2(MaxLmul) when VREGFILE_ERR_EN is undefined.

Reset
REQ-032 rst_i SHALL force IDLE, clear counters, g, rs1..rs3 and rd, and drive busy_o, op_valid_o, res_ready_o, done_o and err_o to 0.
REQ-033 Reset mid-operation SHALL abort without any RAM write and without done_o; RAM contents are not cleared.

Configuration
REQ-034 With VREGFILE_ERR_EN defined, start_i SHALL be rejected (err_o pulse next cycle, remain IDLE, no RAM access) if lmul_i > log2(MaxLmul) or any used base address (sources per num_operands, waddr if we) is not a multiple of 2**lmul_i.
REQ-035 Without VREGFILE_ERR_EN, err_o SHALL be tied to 0 and REQ-031 applies.

Verification
REQ-036 Preloaded v1=0x00000004_00000003_00000002_00000001, v2=0x10..40 pattern; start with num_operands=2, lmul=0, a=1, b=2, w=3, ready/valid always high -> elements (4,0x40),(3,0x30),(2,0x20),(1,0x10) issued in order; sums written back yield v3=0x44_33_22_11 pattern; done_o one pulse.
REQ-037 Same op with op_ready_i toggling every other cycle and res_valid_i delayed 3 cycles -> identical v3, no element lost or duplicated.
REQ-038 lmul=2, a=4, w=8, num_operands=1 -> reads v4..v7, writes v8..v11 in order, exactly one done_o after fourth WRITE.
REQ-039 rst_i asserted during STREAM of a we=1 op -> destination register unchanged, busy_o=0 next cycle, no done_o.
REQ-040 VREGFILE_ERR_EN defined, lmul=1, a=3 -> err_o pulse, busy_o stays 0, RAM untouched; undefined -> op runs on v3,v4.
REQ-041 a=31, lmul=1, ERR undefined -> second read addresses v0 (wrap).
